// File: rtl/cnn_requant_pool_stage.sv
// cnn_requant_pool_stage
//
// Requantises a raster-order stream of CO-channel conv results, applies an
// optional ReLU and an optional 2x2/stride-2 max pool, and emits the reduced
// stream with output coordinates.
//
// Handshake: i_in_valid qualifies i_in_fmap for exactly one cycle; there is
// no ready, so the stage accepts every valid sample. o_ot_valid qualifies
// o_ot_fmap/o_ot_x/o_ot_y for one cycle; gaps on the input appear as gaps on
// the output.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   i_in_valid     input sample valid
//   i_in_fmap      CO signed I_BW-bit channels, channel c at [c*I_BW +: I_BW]
//   i_shift        right-shift amount        (latched at frame start)
//   i_relu_en      ReLU enable               (latched at frame start)
//   i_pool_en      1 = 2x2 max pool, 0 = bypass (latched at frame start)
//   o_ot_valid     output sample valid
//   o_ot_fmap      CO signed O_BW-bit channels
//   o_ot_x/o_ot_y  output column / row
//   o_frame_done   pulse with the last output of a frame
//   o_sat          sticky saturation flag for the current frame
module cnn_requant_pool_stage #(
  parameter int CO    = 3,
  parameter int I_BW  = 20,
  parameter int O_BW  = 20,
  parameter int SH_BW = 5,
  parameter int IN_W  = 24,
  parameter int IN_H  = 24,
  parameter int XW    = $clog2(IN_W),
  parameter int YW    = $clog2(IN_H)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_in_valid,
  input  logic [CO*I_BW-1:0]   i_in_fmap,
  input  logic [SH_BW-1:0]     i_shift,
  input  logic                 i_relu_en,
  input  logic                 i_pool_en,
  output logic                 o_ot_valid,
  output logic [CO*O_BW-1:0]   o_ot_fmap,
  output logic [XW-1:0]        o_ot_x,
  output logic [YW-1:0]        o_ot_y,
  output logic                 o_frame_done,
  output logic                 o_sat
);

  localparam int LW  = CO * O_BW;
  localparam int LBD = IN_W / 2;
  localparam int LAW = $clog2(LBD);

  localparam logic [XW-1:0] X_LAST  = XW'(IN_W - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IN_H - 1);
  localparam logic [XW-1:0] PX_LAST = XW'(IN_W / 2 - 1);
  localparam logic [YW-1:0] PY_LAST = YW'(IN_H / 2 - 1);

  // ---------------------------------------------------------------------------
  // Frame tracking and mode latching
  // ---------------------------------------------------------------------------
  logic [XW-1:0]    in_x_q, in_x_d;
  logic [YW-1:0]    in_y_q, in_y_d;
  logic [SH_BW-1:0] shift_q;
  logic             relu_q, pool_q;
  logic             frame_start;
  logic [SH_BW-1:0] cur_shift;
  logic             cur_relu, cur_pool;

  assign frame_start = i_in_valid && (in_x_q == '0) && (in_y_q == '0);

  // The first sample of a frame already uses the new modes.
  assign cur_shift = frame_start ? i_shift   : shift_q;
  assign cur_relu  = frame_start ? i_relu_en : relu_q;
  assign cur_pool  = frame_start ? i_pool_en : pool_q;

  always_comb begin
    in_x_d = in_x_q;
    in_y_d = in_y_q;
    if (i_in_valid) begin
      if (in_x_q == X_LAST) begin
        in_x_d = '0;
        in_y_d = (in_y_q == Y_LAST) ? '0 : in_y_q + YW'(1);
      end else begin
        in_x_d = in_x_q + XW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: requantise (round-half-up shift, saturate, ReLU) per channel
  // ---------------------------------------------------------------------------
  logic [LW-1:0] rq_data;
  logic          rq_sat;

  always_comb begin : requant
    logic signed [I_BW-1:0]  x;
    logic signed [I_BW:0]    sum;
    logic signed [I_BW:0]    rnd;
    logic signed [I_BW:0]    r;
    logic [I_BW-O_BW+1:0]    hi;
    logic [O_BW-1:0]         o;
    rq_data = '0;
    rq_sat  = 1'b0;
    x = '0; sum = '0; rnd = '0; r = '0; hi = '0; o = '0;
    for (int c = 0; c < CO; c++) begin
      x = $signed(i_in_fmap[c*I_BW +: I_BW]);
      if (cur_shift == '0) begin
        r = {x[I_BW-1], x};
      end else if (32'(cur_shift) >= I_BW) begin
        // Every magnitude bit is shifted out: only the sign survives.
        r = x[I_BW-1] ? '1 : '0;
      end else begin
        // One guard bit above I_BW keeps the rounding add from wrapping.
        rnd = (I_BW+1)'(1) << (cur_shift - SH_BW'(1));
        sum = {x[I_BW-1], x} + rnd;
        r   = sum >>> cur_shift;
      end
      // In range iff every bit from the output sign bit upwards agrees.
      hi = r[I_BW:O_BW-1];
      if ((&hi) || !(|hi)) begin
        o = r[O_BW-1:0];
      end else begin
        o      = r[I_BW] ? {1'b1, {(O_BW-1){1'b0}}} : {1'b0, {(O_BW-1){1'b1}}};
        rq_sat = 1'b1;
      end
      if (cur_relu && o[O_BW-1]) o = '0;
      rq_data[c*O_BW +: O_BW] = o;
    end
  end

  logic          s1_valid_q;
  logic [LW-1:0] s1_data_q;
  logic [XW-1:0] s1_x_q;
  logic [YW-1:0] s1_y_q;
  logic          s1_pool_q;   // pool mode travels with the sample across frames
  logic          sat_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_x_q     <= '0;
      in_y_q     <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      pool_q     <= 1'b1;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_pool_q  <= 1'b1;
      sat_q      <= 1'b0;
    end else begin
      in_x_q     <= in_x_d;
      in_y_q     <= in_y_d;
      s1_valid_q <= i_in_valid;
      if (frame_start) begin
        shift_q <= i_shift;
        relu_q  <= i_relu_en;
        pool_q  <= i_pool_en;
      end
      if (i_in_valid) begin
        s1_data_q <= rq_data;
        s1_x_q    <= in_x_q;
        s1_y_q    <= in_y_q;
        s1_pool_q <= cur_pool;
        sat_q     <= (frame_start ? 1'b0 : sat_q) | rq_sat;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: 2x2 max pool through a horizontal register and a line buffer
  // ---------------------------------------------------------------------------
  function automatic logic [LW-1:0] vmax(input logic [LW-1:0] a,
                                         input logic [LW-1:0] b);
    logic [LW-1:0] m;
    m = '0;
    for (int c = 0; c < CO; c++) begin
      m[c*O_BW +: O_BW] = ($signed(a[c*O_BW +: O_BW]) > $signed(b[c*O_BW +: O_BW]))
                          ? a[c*O_BW +: O_BW] : b[c*O_BW +: O_BW];
    end
    return m;
  endfunction

  logic [LW-1:0]  lb_q [LBD];
  logic [LW-1:0]  hold_q, hold_d;
  logic [LW-1:0]  h_max, lb_rd, pooled;
  logic [LAW-1:0] lb_idx;
  logic           lb_we;

  logic           ot_valid_q, ot_valid_d;
  logic [LW-1:0]  ot_fmap_q, ot_fmap_d;
  logic [XW-1:0]  ot_x_q, ot_x_d;
  logic [YW-1:0]  ot_y_q, ot_y_d;
  logic           done_q, done_d;

  assign lb_idx = LAW'(s1_x_q >> 1);
  assign h_max  = vmax(hold_q, s1_data_q);
  assign lb_rd  = lb_q[lb_idx];
  assign pooled = vmax(lb_rd, h_max);

  always_comb begin
    hold_d     = hold_q;
    lb_we      = 1'b0;
    ot_valid_d = 1'b0;
    ot_fmap_d  = ot_fmap_q;
    ot_x_d     = ot_x_q;
    ot_y_d     = ot_y_q;
    done_d     = 1'b0;
    if (s1_valid_q) begin
      if (s1_pool_q) begin
        // An odd trailing column/row is held or written but never completes
        // a window, so it drops out naturally.
        if (!s1_x_q[0]) begin
          hold_d = s1_data_q;
        end else if (!s1_y_q[0]) begin
          lb_we = 1'b1;
        end else begin
          ot_valid_d = 1'b1;
          ot_fmap_d  = pooled;
          ot_x_d     = s1_x_q >> 1;
          ot_y_d     = s1_y_q >> 1;
          done_d     = ((s1_x_q >> 1) == PX_LAST) && ((s1_y_q >> 1) == PY_LAST);
        end
      end else begin
        ot_valid_d = 1'b1;
        ot_fmap_d  = s1_data_q;
        ot_x_d     = s1_x_q;
        ot_y_d     = s1_y_q;
        done_d     = (s1_x_q == X_LAST) && (s1_y_q == Y_LAST);
      end
    end
  end

  // Line buffer has no reset: each entry is written on an even row before
  // the matching odd row reads it.
  always_ff @(posedge clk) begin
    if (lb_we) lb_q[lb_idx] <= h_max;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q     <= '0;
      ot_valid_q <= 1'b0;
      ot_fmap_q  <= '0;
      ot_x_q     <= '0;
      ot_y_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      ot_valid_q <= ot_valid_d;
      ot_fmap_q  <= ot_fmap_d;
      ot_x_q     <= ot_x_d;
      ot_y_q     <= ot_y_d;
      done_q     <= done_d;
    end
  end

  assign o_ot_valid   = ot_valid_q;
  assign o_ot_fmap    = ot_fmap_q;
  assign o_ot_x       = ot_x_q;
  assign o_ot_y       = ot_y_q;
  assign o_frame_done = done_q;
  assign o_sat        = sat_q;

endmodule

// File: tb/tb_cnn_requant_pool_stage.sv
// Directed bench for cnn_requant_pool_stage with a 2-channel, 12-bit in /
// 8-bit out, 4x4-frame configuration. Each output is checked against a
// hand-computed expectation queued by the stimulus, including its cycle.
module tb_cnn_requant_pool_stage;

  localparam int CO = 2, I_BW = 12, O_BW = 8, SH_BW = 5;
  localparam int IN_W = 4, IN_H = 4, XW = 2, YW = 2;
  localparam int EW = CO*O_BW + XW + YW + 1 + 32;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                 i_in_valid;
  logic [CO*I_BW-1:0]   i_in_fmap;
  logic [SH_BW-1:0]     i_shift;
  logic                 i_relu_en;
  logic                 i_pool_en;
  logic                 o_ot_valid;
  logic [CO*O_BW-1:0]   o_ot_fmap;
  logic [XW-1:0]        o_ot_x;
  logic [YW-1:0]        o_ot_y;
  logic                 o_frame_done;
  logic                 o_sat;

  cnn_requant_pool_stage #(
    .CO(CO), .I_BW(I_BW), .O_BW(O_BW), .SH_BW(SH_BW),
    .IN_W(IN_W), .IN_H(IN_H), .XW(XW), .YW(YW)
  ) dut (
    .clk(clk), .reset(reset),
    .i_in_valid(i_in_valid), .i_in_fmap(i_in_fmap),
    .i_shift(i_shift), .i_relu_en(i_relu_en), .i_pool_en(i_pool_en),
    .o_ot_valid(o_ot_valid), .o_ot_fmap(o_ot_fmap),
    .o_ot_x(o_ot_x), .o_ot_y(o_ot_y),
    .o_frame_done(o_frame_done), .o_sat(o_sat)
  );

  // scoreboard: {ch1, ch0, x, y, done, expected cycle}
  logic [EW-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int samp_cyc = 0;

  // stimulus / expectation tables for one 16-sample frame
  int a0[16], a1[16];   // input channels
  int bp0[16], bp1[16]; // bypass outputs
  int pl0[4], pl1[4];   // pooled outputs, window order (0,0),(1,0),(0,1),(1,1)

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic [EW-1:0] e;
    if (o_frame_done && !o_ot_valid) begin
      vectors++;
      miscompares++;
      $error("FAIL done_without_valid: observed 1 expected 0 at cycle %0d", cyc);
    end
    if (o_ot_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_output: fmap %0h x %0d y %0d at cycle %0d, expected none",
               o_ot_fmap, o_ot_x, o_ot_y, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("out_fmap",  32'(o_ot_fmap),    32'(e[EW-1 -: CO*O_BW]));
        chk("out_x",     32'(o_ot_x),       32'(e[32+1+YW +: XW]));
        chk("out_y",     32'(o_ot_y),       32'(e[32+1 +: YW]));
        chk("out_done",  32'(o_frame_done), 32'(e[32]));
        chk("out_cycle", cyc,               e[31:0]);
      end
      if (o_frame_done) done_cnt++;
    end
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    i_in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic smp(input int a, input int b);
    i_in_valid = 1'b1;
    i_in_fmap  = {I_BW'(b), I_BW'(a)};
    samp_cyc   = cyc;
    tick();
    i_in_valid = 1'b0;
  endtask

  // expectation tied to the most recent sample: two cycles later
  task automatic push_exp(input int e0, input int e1, input int ex, input int ey, input bit d);
    exp_q.push_back({O_BW'(e1), O_BW'(e0), XW'(ex), YW'(ey), d, 32'(samp_cyc + 2)});
  endtask

  task automatic run_frame(input bit pool_exp, input int gap_pct, input int toggle_at);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin
        for (int g = 0; g < 3; g++) begin
          if ($urandom_range(0, 99) < gap_pct) idle(1);
        end
      end
      if (i == toggle_at) i_pool_en = ~i_pool_en;
      smp(a0[i], a1[i]);
      if (pool_exp) begin
        if (((i % 4) % 2 == 1) && ((i / 4) % 2 == 1))
          push_exp(pl0[(i/8)*2 + (i%4)/2], pl1[(i/8)*2 + (i%4)/2], (i%4)/2, i/8, i == 15);
      end else begin
        push_exp(bp0[i], bp1[i], i % 4, i / 4, i == 15);
      end
    end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 16; i++) begin
      a0[i] = i;  a1[i] = -i;
      bp0[i] = i; bp1[i] = -i;
    end
    pl0[0] = 5; pl0[1] = 7;  pl0[2] = 13; pl0[3] = 15;
    pl1[0] = 0; pl1[1] = -2; pl1[2] = -8; pl1[3] = -10;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(o_ot_valid),   32'(0));
    chk({tag, "_fmap"},  32'(o_ot_fmap),    32'(0));
    chk({tag, "_x"},     32'(o_ot_x),       32'(0));
    chk({tag, "_y"},     32'(o_ot_y),       32'(0));
    chk({tag, "_done"},  32'(o_frame_done), 32'(0));
    chk({tag, "_sat"},   32'(o_sat),        32'(0));
  endtask

  initial begin
    reset = 1'b1;
    i_in_valid = 1'b0;
    i_in_fmap = '0;
    i_shift = '0;
    i_relu_en = 1'b0;
    i_pool_en = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    idle(1);

    // pool max over a 0..15 ramp (channel 1 carries the negated ramp)
    load_ramp();
    run_frame(1'b1, 0, -1);
    idle(4);
    chk("pool_sat", 32'(o_sat), 32'(0));
    chk("pool_done_cnt", done_cnt, 1);
    chk("hold_valid", 32'(o_ot_valid), 32'(0));
    chk("hold_fmap", 32'(o_ot_fmap), 32'({8'hF6, 8'h0F}));
    chk("hold_x", 32'(o_ot_x), 32'(1));
    chk("hold_y", 32'(o_ot_y), 32'(1));

    // rounding in bypass, shift 2
    i_shift = 5'd2;
    i_pool_en = 1'b0;
    a0[0] = 6;  a0[1] = -6; a0[2] = 5;  a0[3] = -5;
    a1[0] = 7;  a1[1] = -7; a1[2] = -2; a1[3] = 2;
    bp0[0] = 2; bp0[1] = -1; bp0[2] = 1; bp0[3] = -1;
    bp1[0] = 2; bp1[1] = -2; bp1[2] = 0; bp1[3] = 1;
    for (int i = 4; i < 16; i++) begin
      a0[i] = 4*i; a1[i] = -4*i;
      bp0[i] = i;  bp1[i] = -i;
    end
    run_frame(1'b0, 0, -1);
    idle(4);
    chk("round_done_cnt", done_cnt, 2);
    chk("round_sat", 32'(o_sat), 32'(0));

    // saturation, shift 0, bypass
    i_shift = 5'd0;
    a0[0] = 300; a0[1] = -300; a1[0] = 127; a1[1] = -128;
    bp0[0] = 127; bp0[1] = -128; bp1[0] = 127; bp1[1] = -128;
    for (int i = 2; i < 16; i++) begin
      a0[i] = i; a1[i] = 0;
      bp0[i] = i; bp1[i] = 0;
    end
    run_frame(1'b0, 0, -1);
    idle(4);
    chk("sat_sticky", 32'(o_sat), 32'(1));
    chk("sat_done_cnt", done_cnt, 3);

    // ReLU plus pool; o_sat cleared at this frame's start
    i_relu_en = 1'b1;
    i_pool_en = 1'b1;
    a0[0] = -3;  a0[1] = -1;  a0[2] = -4;   a0[3] = 9;
    a0[4] = -8;  a0[5] = -2;  a0[6] = 2;    a0[7] = -7;
    a0[8] = 10;  a0[9] = -20; a0[10] = -50; a0[11] = 60;
    a0[12] = 30; a0[13] = -40; a0[14] = -70; a0[15] = 80;
    for (int i = 0; i < 16; i++) a1[i] = i;
    pl0[0] = 0; pl0[1] = 9; pl0[2] = 30; pl0[3] = 80;
    pl1[0] = 5; pl1[1] = 7; pl1[2] = 13; pl1[3] = 15;
    run_frame(1'b1, 0, -1);
    idle(4);
    chk("relu_sat_cleared", 32'(o_sat), 32'(0));
    chk("relu_done_cnt", done_cnt, 4);

    // gaps, then a back-to-back bypass frame with a mid-frame pool toggle
    i_relu_en = 1'b0;
    load_ramp();
    run_frame(1'b1, 50, -1);
    i_pool_en = 1'b0;
    run_frame(1'b0, 50, 8);
    idle(4);
    chk("b2b_done_cnt", done_cnt, 6);

    // reset mid-frame, then a clean frame
    i_pool_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      smp(100 + i, -(100 + i));
      if (i == 5) push_exp(105, -100, 0, 0, 1'b0);
    end
    reset = 1'b1;
    tick();
    check_reset_outputs("midreset");
    reset = 1'b0;
    run_frame(1'b1, 0, -1);
    idle(4);
    chk("midreset_done_cnt", done_cnt, 7);
    chk("midreset_sat", 32'(o_sat), 32'(0));

    chk("exp_q_empty", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
